switch_debounce_sync: RTL and testbench

- Upstream conditioning stage for the Basys3 slide-switch bank.
- Turns raw asynchronous, bouncing `sw` pins into:
  - a clean, synchronous switch bus,
  - single-cycle rise/fall event strobes,
  - a registered count of switches set.
- Downstream parity/LED logic consumes these outputs instead of edge-triggering on raw pins.
- Everything runs on the single 100 MHz board clock.

---
 rtl/basys3_pkg.sv | 11 +
 rtl/debounce_bit.sv | 51 +++++
 rtl/switch_debounce_sync.sv | 52 +++++
 tb/tb_switch_debounce_sync.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/basys3_pkg.sv
// Shared board constants for the Basys3 slide-switch front end.
//   CLK_HZ              board clock frequency
//   DEBOUNCE_MS         switch settle time
//   DEBOUNCE_CYCLES_DEF default debounce length in clock cycles
//   NUM_SW              number of slide switches on the board
package basys3_pkg;
  localparam int CLK_HZ              = 100_000_000;
  localparam int DEBOUNCE_MS         = 10;
  localparam int DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;
  localparam int NUM_SW              = 8;
endpackage

// File: rtl/debounce_bit.sv
// Single-switch conditioner: 2-flop synchronizer, qualification counter,
// stable level flop and registered rise/fall strobes.
//   clk, rst   board clock, synchronous active-high reset
//   sw         raw asynchronous pin
//   clean      debounced level
//   clean_nxt  next-state of clean (lets the parent register derived values
//              in the same cycle as clean)
//   rise/fall  one-cycle strobes on clean 0->1 / 1->0
module debounce_bit #(
  parameter  int DEBOUNCE_CYCLES = basys3_pkg::DEBOUNCE_CYCLES_DEF,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic sw,
  output logic clean,
  output logic clean_nxt,
  output logic rise,
  output logic fall
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s2;
  logic [CNT_W-1:0] cnt;
  logic             differ, accept;

  assign differ    = (s2 != clean);
  // cnt counts edges already spent differing; the DEBOUNCE_CYCLES-th accepts.
  assign accept    = differ && (cnt == LAST);
  assign clean_nxt = rst ? 1'b0 : (accept ? s2 : clean);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= sw;
      s2    <= s1;
      clean <= clean_nxt;
      rise  <= accept &  s2;
      fall  <= accept & ~s2;
      // Any return to the accepted level restarts qualification.
      if (differ && !accept) cnt <= cnt + 1'b1;
      else                   cnt <= '0;
    end
  end
endmodule

// File: rtl/switch_debounce_sync.sv
// Slide-switch bank conditioner.
//   clk, rst    board clock, synchronous active-high reset
//   sw          raw switch pins (asynchronous, bouncing)
//   sw_clean    debounced synchronous levels
//   sw_rise     per-bit one-cycle strobe on clean 0->1
//   sw_fall     per-bit one-cycle strobe on clean 1->0
//   sw_changed  OR of all rise/fall strobes
//   ones_count  popcount of sw_clean, registered alongside it
module switch_debounce_sync
  import basys3_pkg::*;
#(
  parameter  int WIDTH           = NUM_SW,
  parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  localparam int OW              = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sw_changed,
  output logic [OW-1:0]    ones_count
);
  logic [WIDTH-1:0] clean_nxt;
  logic [OW-1:0]    pop_nxt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bit (
      .clk       (clk),
      .rst       (rst),
      .sw        (sw[i]),
      .clean     (sw_clean[i]),
      .clean_nxt (clean_nxt[i]),
      .rise      (sw_rise[i]),
      .fall      (sw_fall[i])
    );
  end

  // Popcount of the next-state bus so ones_count lands with sw_clean.
  always_comb begin
    pop_nxt = '0;
    for (int i = 0; i < WIDTH; i++) pop_nxt = pop_nxt + OW'(clean_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (rst) ones_count <= '0;
    else     ones_count <= pop_nxt;
  end

  assign sw_changed = |(sw_rise | sw_fall);
endmodule

// File: tb/tb_switch_debounce_sync.sv
module tb_switch_debounce_sync;
  localparam int DC = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] sw;
  logic [7:0] sw_clean, sw_rise, sw_fall;
  logic       sw_changed;
  logic [3:0] ones_count;

  switch_debounce_sync #(.WIDTH(8), .DEBOUNCE_CYCLES(DC)) dut (
    .clk        (clk),
    .rst        (rst),
    .sw         (sw),
    .sw_clean   (sw_clean),
    .sw_rise    (sw_rise),
    .sw_fall    (sw_fall),
    .sw_changed (sw_changed),
    .ones_count (ones_count)
  );

  always #5 clk = ~clk;

  int passes = 0;
  int total  = 0;

  // Reference: sw sampled at edge k is seen by the debouncer at edge k+2.
  // A bit flips once the last DC observed values all differ from its
  // accepted level, counting only observations since the last reset.
  logic [7:0] swq[$];
  logic [7:0] obsq[$];
  logic [7:0] e_clean, e_rise, e_fall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int pop8(input logic [7:0] v);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic model_edge(input logic [7:0] s, input logic r);
    logic [7:0] seen, nc;
    if (r) begin
      swq.delete(); obsq.delete();
      e_clean = '0; e_rise = '0; e_fall = '0;
    end else begin
      seen = (swq.size() >= 2) ? swq[swq.size()-2] : 8'h00;
      swq.push_back(s);
      if (swq.size() > 2) void'(swq.pop_front());
      obsq.push_back(seen);
      if (obsq.size() > DC) void'(obsq.pop_front());
      nc = e_clean;
      for (int b = 0; b < 8; b++) begin
        bit all_diff = (obsq.size() >= DC);
        for (int j = 0; j < obsq.size(); j++)
          if (obsq[j][b] == e_clean[b]) all_diff = 0;
        if (all_diff) nc[b] = ~e_clean[b];
      end
      e_rise  = nc & ~e_clean;
      e_fall  = ~nc & e_clean;
      e_clean = nc;
    end
  endtask

  task automatic step(input logic [7:0] s, input logic r = 1'b0);
    sw = s; rst = r;
    @(posedge clk);
    model_edge(s, r);
    #1;
    chk("sw_clean",   32'(sw_clean),   32'(e_clean));
    chk("sw_rise",    32'(sw_rise),    32'(e_rise));
    chk("sw_fall",    32'(sw_fall),    32'(e_fall));
    chk("sw_changed", 32'(sw_changed), 32'(|(e_rise | e_fall)));
    chk("ones_count", 32'(ones_count), 32'(pop8(e_clean)));
  endtask

  initial begin
    int rises;
    logic [7:0] cur;

    // Reset then idle
    repeat (3) step(8'h00, 1'b1);
    repeat (12) step(8'h00);
    chk("idle_clean", 32'(sw_clean), 32'h0);

    // Clean rise on bit 0: accepted at the 6th edge after the change
    for (int i = 1; i <= 8; i++) begin
      step(8'h01);
      if (i == 5) chk("rise_early", 32'(sw_clean), 32'h00);
      if (i == 6) begin
        chk("rise_t6_clean", 32'(sw_clean), 32'h01);
        chk("rise_t6_pulse", 32'(sw_rise), 32'h01);
        chk("rise_t6_ones",  32'(ones_count), 32'd1);
      end
      if (i == 7) chk("rise_t7_pulse", 32'(sw_rise), 32'h00);
    end
    repeat (8) step(8'h00);

    // Bounce on bit 3 is rejected, then a steady high is accepted once
    step(8'h08); step(8'h00); step(8'h08); step(8'h00);
    repeat (8) step(8'h00);
    chk("bounce_clean", 32'(sw_clean), 32'h00);
    rises = 0;
    repeat (8) begin step(8'h08); if (sw_rise[3]) rises++; end
    chk("bounce_one_rise", 32'(rises), 32'd1);
    repeat (8) step(8'h00);

    // Simultaneous rise of all bits, then partial fall
    for (int i = 1; i <= 8; i++) begin
      step(8'hFF);
      if (i == 6) begin
        chk("all_rise", 32'(sw_rise), 32'hFF);
        chk("all_ones", 32'(ones_count), 32'd8);
      end
    end
    for (int i = 1; i <= 8; i++) begin
      step(8'h0F);
      if (i == 6) begin
        chk("hi_fall", 32'(sw_fall), 32'hF0);
        chk("hi_ones", 32'(ones_count), 32'd4);
      end
    end
    repeat (8) step(8'h00);

    // Reset in the middle of qualifying bit 5
    repeat (3) step(8'h20);
    step(8'h20, 1'b1);
    for (int i = 1; i <= 10; i++) begin
      step(8'h20);
      if (i == 5) chk("rst_mid_early", 32'(sw_clean), 32'h00);
      if (i == 6) chk("rst_mid_rise", 32'(sw_rise), 32'h20);
    end
    repeat (8) step(8'h00);

    // Held level: one pulse only
    rises = 0;
    repeat (106) begin step(8'hA5); if (sw_rise != 8'h00) rises++; end
    chk("held_pulses", 32'(rises), 32'd1);
    chk("held_clean",  32'(sw_clean), 32'hA5);

    // Randomized: mostly-held levels with bursts of bounce and rare resets
    cur = 8'hA5;
    repeat (400) begin
      if ($urandom_range(0, 7) == 0) cur = 8'($urandom);
      if ($urandom_range(0, 3) == 0) step(cur ^ 8'($urandom), 1'b0);
      else step(cur, ($urandom_range(0, 79) == 0));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
